// File: rtl/dma_pkg.sv
`default_nettype none
// ===== dma_pkg | shared types and register map for the DMA engine | rev 1.0 =====
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_e;

  localparam logic [1:0] REG_SRC_LO = 2'd0;
  localparam logic [1:0] REG_SRC_HI = 2'd1;
  localparam logic [1:0] REG_DST    = 2'd2;
  localparam logic [1:0] REG_CTL    = 2'd3;

  localparam int CTL_FILL_BIT = 15;

endpackage
`default_nettype wire

// File: rtl/dma_rr_arbiter.sv
`default_nettype none
// ===== dma_rr_arbiter | round-robin pick after last grant (combinational) | rev 1.0 =====
module dma_rr_arbiter #(
  parameter int CHANNELS = 2,
  parameter int IDX_W    = 1
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [IDX_W-1:0]    last,
  output logic [CHANNELS-1:0] grant,
  output logic [IDX_W-1:0]    idx
);

  logic found;

  // First pass favours channels above the pointer, second pass wraps around.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!found && req[i] && (IDX_W'(i) > last)) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
      end
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (!found && req[i] && (IDX_W'(i) <= last)) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dma_multi.sv
`default_nettype none
// ===== dma_multi | multi-channel ROM copy / constant fill DMA engine | rev 1.0 =====
module dma_multi
  import dma_pkg::*;
#(
  parameter  int CHANNELS   = 2,
  parameter  int ADDR_W     = 16,
  parameter  int ROM_ADDR_W = 23,
  parameter  int DATA_W     = 16,
  parameter  int LEN_W      = 12,
  localparam int IDX_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  write,
  input  logic [1:0]            wr_mode,
  input  logic [IDX_W-1:0]      wr_chan,
  input  logic [DATA_W-1:0]     ctrl_data,
  output logic [ROM_ADDR_W-1:0] src_addr,
  output logic                  load_rom,
  input  logic [DATA_W-1:0]     src_data,
  input  logic                  ready,
  output logic [ADDR_W-1:0]     dst_addr,
  output logic                  dst_write,
  output logic [DATA_W-1:0]     dst_data,
  output logic                  proc_en,
  output logic [CHANNELS-1:0]   busy,
  output logic [CHANNELS-1:0]   done
);

  localparam int HI_W = ROM_ADDR_W - 16;

  logic [ROM_ADDR_W-1:0] ch_src [CHANNELS];
  logic [ADDR_W-1:0]     ch_dst [CHANNELS];
  logic [LEN_W-1:0]      ch_len [CHANNELS];
  logic [CHANNELS-1:0]   ch_fill;

  dma_state_e          state, state_nx;
  logic [IDX_W-1:0]    cur, last;
  logic [CHANNELS-1:0] arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic [CHANNELS-1:0] fin;
  logic                host_wr;
  logic                unused_ctrl;

  assign host_wr     = en & write;
  assign unused_ctrl = ^ctrl_data;

  dma_rr_arbiter #(
    .CHANNELS(CHANNELS),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req  (busy),
    .last (last),
    .grant(arb_grant),
    .idx  (arb_idx)
  );

  // Channel finishing its last word in the current WRITE cycle.
  always_comb begin
    fin = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      fin[c] = (state == ST_WRITE) && (cur == IDX_W'(c)) && (ch_len[c] == LEN_W'(1));
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (|busy) state_nx = ST_ARB;
      ST_ARB: begin
        if (!(|arb_grant))       state_nx = ST_IDLE;
        else if (ch_fill[arb_idx]) state_nx = ST_WRITE;
        else                     state_nx = ST_REQ;
      end
      ST_REQ:   state_nx = ST_WAIT;
      ST_WAIT:  if (ready) state_nx = ST_WRITE;
      ST_WRITE: state_nx = (|(busy & ~fin)) ? ST_ARB : ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they are valid for the whole state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      proc_en   <= 1'b1;
      load_rom  <= 1'b0;
      dst_write <= 1'b0;
    end else begin
      state     <= state_nx;
      proc_en   <= (state_nx == ST_IDLE);
      load_rom  <= (state_nx == ST_REQ);
      dst_write <= (state_nx == ST_WRITE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur      <= '0;
      last     <= IDX_W'(CHANNELS - 1);
      src_addr <= '0;
      dst_addr <= '0;
      dst_data <= '0;
      busy     <= '0;
      done     <= '0;
      ch_fill  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        ch_src[c] <= '0;
        ch_dst[c] <= '0;
        ch_len[c] <= '0;
      end
    end else begin
      if (state == ST_ARB && |arb_grant) begin
        cur      <= arb_idx;
        last     <= arb_idx;
        src_addr <= ch_src[arb_idx];
        dst_addr <= ch_dst[arb_idx];
        if (ch_fill[arb_idx]) dst_data <= DATA_W'(ch_src[arb_idx][15:0]);
      end
      if (state == ST_WAIT && ready) dst_data <= src_data;

      for (int c = 0; c < CHANNELS; c++) begin
        if (state == ST_WRITE && cur == IDX_W'(c)) begin
          ch_dst[c] <= ch_dst[c] + ADDR_W'(1);
          if (!ch_fill[c]) ch_src[c] <= ch_src[c] + ROM_ADDR_W'(1);
          ch_len[c] <= ch_len[c] - LEN_W'(1);
          if (fin[c]) begin
            busy[c] <= 1'b0;
            done[c] <= 1'b1;
          end
        end
        // Host writes only land on idle channels, so they never race the engine.
        if (host_wr && wr_chan == IDX_W'(c) && !busy[c]) begin
          case (wr_mode)
            REG_SRC_LO: ch_src[c][15:0]            <= ctrl_data[15:0];
            REG_SRC_HI: ch_src[c][ROM_ADDR_W-1:16] <= ctrl_data[HI_W-1:0];
            REG_DST:    ch_dst[c]                  <= ctrl_data[ADDR_W-1:0];
            REG_CTL: begin
              ch_len[c]  <= ctrl_data[LEN_W-1:0];
              ch_fill[c] <= ctrl_data[CTL_FILL_BIT];
              if (ctrl_data[LEN_W-1:0] == '0) begin
                busy[c] <= 1'b0;
                done[c] <= 1'b1;
              end else begin
                busy[c] <= 1'b1;
                done[c] <= 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_multi.sv
`default_nettype none
// ===== tb_dma_multi | directed table, corner sequences and random round-robin model | rev 1.0 =====
module tb_dma_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, write = 1'b0;
  logic [1:0]  wr_mode = '0;
  logic [0:0]  wr_chan = '0;
  logic [15:0] ctrl_data = '0;
  logic [22:0] src_addr;
  logic        load_rom;
  logic [15:0] src_data = '0;
  logic        ready = 1'b0;
  logic [15:0] dst_addr;
  logic        dst_write;
  logic [15:0] dst_data;
  logic        proc_en;
  logic [1:0]  busy, done;

  dma_multi #(
    .CHANNELS(2), .ADDR_W(16), .ROM_ADDR_W(23), .DATA_W(16), .LEN_W(12)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .write(write), .wr_mode(wr_mode), .wr_chan(wr_chan),
    .ctrl_data(ctrl_data), .src_addr(src_addr), .load_rom(load_rom), .src_data(src_data),
    .ready(ready), .dst_addr(dst_addr), .dst_write(dst_write), .dst_data(dst_data),
    .proc_en(proc_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    int          ch;
    bit          fill;
    logic [22:0] src;
    logic [15:0] dst;
    int          len;
    int          exp_writes;
    int          exp_loads;
    int          exp_low;
    logic [15:0] f_addr, f_data, l_addr, l_data;
    int          exp_gap;
  } vec_t;

  int   checks = 0, failures = 0;
  int   cyc = 0, low_cnt = 0, load_cnt = 0;
  int   rom_cnt = 0, rom_lat = 1;
  bit   rom_rand = 1'b0;
  logic [22:0] pend = '0;
  wr_t  obs[$];
  wr_t  expq[$];
  int   mptr = 1;
  vec_t vecs[5];

  function automatic logic [15:0] rom(input logic [22:0] a);
    return a[15:0] ^ {9'd0, a[22:16]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: sample outputs at the falling edge, then act as the ROM.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!proc_en) low_cnt++;
    if (load_rom) load_cnt++;
    if (dst_write) obs.push_back('{dst_addr, dst_data, cyc});
    ready = 1'b0;
    if (rom_cnt > 0) begin
      rom_cnt--;
      if (rom_cnt == 0) begin
        ready    = 1'b1;
        src_data = rom(pend);
      end
    end
    if (load_rom) begin
      pend    = src_addr;
      rom_cnt = rom_rand ? int'($urandom_range(1, 3)) : rom_lat;
      if (rom_rand && $urandom_range(0, 3) == 0) begin
        ready    = 1'b1;           // stray pulse during REQ must be ignored
        src_data = ~rom(src_addr);
      end
    end
  endtask

  task automatic wr(input int ch, input logic [1:0] mode, input logic [15:0] d);
    en = 1'b1; write = 1'b1; wr_chan = 1'(ch); wr_mode = mode; ctrl_data = d;
    tick();
    en = 1'b0; write = 1'b0;
  endtask

  task automatic clear_mon();
    obs.delete();
    load_cnt = 0;
    low_cnt  = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; ready = 1'b0; rom_cnt = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic start(input int ch, input bit fill, input int len);
    wr(ch, 2'd3, {fill, 3'b000, 12'(len)});
  endtask

  task automatic wait_idle(input bit junk);
    int n = 0;
    while ((busy != 2'b00 || !proc_en) && n < 2000) begin
      if (junk && busy != 2'b00 && $urandom_range(0, 2) == 0) begin
        int c;
        c = busy[0] ? 0 : 1;
        if (busy == 2'b11) c = int'($urandom_range(0, 1));
        wr(c, 2'($urandom), 16'($urandom));
      end else begin
        tick();
      end
      n++;
    end
    chk("idle_timeout", {63'd0, n < 2000}, 64'd1);
  endtask

  initial begin
    vecs[0] = '{0, 1'b0, 23'h000100, 16'h4000, 3, 3, 3, 12, 16'h4000, 16'h0100, 16'h4002, 16'h0102, 4};
    vecs[1] = '{1, 1'b1, 23'h00BEEF, 16'h2000, 4, 4, 0, 8,  16'h2000, 16'hBEEF, 16'h2003, 16'hBEEF, 2};
    vecs[2] = '{0, 1'b0, 23'h000000, 16'h0000, 0, 0, 0, 0,  16'h0000, 16'h0000, 16'h0000, 16'h0000, 0};
    vecs[3] = '{1, 1'b0, 23'h7FFFFF, 16'hFFFF, 2, 2, 2, 8,  16'hFFFF, 16'hFF80, 16'h0000, 16'h0000, 4};
    vecs[4] = '{0, 1'b1, 23'h001234, 16'hFFFF, 2, 2, 0, 4,  16'hFFFF, 16'h1234, 16'h0000, 16'h1234, 2};

    #1 rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_proc_en",   {63'd0, proc_en},   64'd1);
    chk("rst_load_rom",  {63'd0, load_rom},  64'd0);
    chk("rst_dst_write", {63'd0, dst_write}, 64'd0);
    chk("rst_src_addr",  {41'd0, src_addr},  64'd0);
    chk("rst_dst_addr",  {48'd0, dst_addr},  64'd0);
    chk("rst_dst_data",  {48'd0, dst_data},  64'd0);
    chk("rst_busy",      {62'd0, busy},      64'd0);
    chk("rst_done",      {62'd0, done},      64'd0);

    // Directed single-channel table.
    rom_rand = 1'b0; rom_lat = 1;
    for (int i = 0; i < 5; i++) begin
      vec_t v;
      v = vecs[i];
      wr(v.ch, 2'd0, v.src[15:0]);
      if (!v.fill) wr(v.ch, 2'd1, {9'd0, v.src[22:16]});
      wr(v.ch, 2'd2, v.dst);
      clear_mon();
      start(v.ch, v.fill, v.len);
      chk($sformatf("v%0d_busy_after_start", i), {63'd0, busy[v.ch]}, {63'd0, v.len != 0});
      chk($sformatf("v%0d_done_after_start", i), {63'd0, done[v.ch]}, {63'd0, v.len == 0});
      wait_idle(1'b0);
      chk($sformatf("v%0d_writes", i), 64'(obs.size()), 64'(v.exp_writes));
      chk($sformatf("v%0d_loads", i), 64'(load_cnt), 64'(v.exp_loads));
      chk($sformatf("v%0d_proc_low", i), 64'(low_cnt), 64'(v.exp_low));
      chk($sformatf("v%0d_done", i), {63'd0, done[v.ch]}, 64'd1);
      if (obs.size() > 0 && v.exp_writes > 0) begin
        chk($sformatf("v%0d_first", i), {32'd0, obs[0].addr, obs[0].data}, {32'd0, v.f_addr, v.f_data});
        chk($sformatf("v%0d_last", i), {32'd0, obs[obs.size()-1].addr, obs[obs.size()-1].data},
            {32'd0, v.l_addr, v.l_data});
      end
      for (int j = 1; j < obs.size(); j++)
        chk($sformatf("v%0d_gap%0d", i, j), 64'(obs[j].cyc - obs[j-1].cyc), 64'(v.exp_gap));
    end

    // Two copies started back to back interleave word by word.
    do_reset();
    wr(0, 2'd0, 16'h0200); wr(0, 2'd1, 16'h0000); wr(0, 2'd2, 16'h1000);
    wr(1, 2'd0, 16'h0300); wr(1, 2'd1, 16'h0000); wr(1, 2'd2, 16'h3000);
    clear_mon();
    start(0, 1'b0, 2);
    start(1, 1'b0, 2);
    wait_idle(1'b0);
    begin
      logic [31:0] exp2 [4];
      exp2[0] = {16'h1000, 16'h0200};
      exp2[1] = {16'h3000, 16'h0300};
      exp2[2] = {16'h1001, 16'h0201};
      exp2[3] = {16'h3001, 16'h0301};
      chk("rr_count", 64'(obs.size()), 64'd4);
      for (int j = 0; j < 4 && j < obs.size(); j++)
        chk($sformatf("rr_word%0d", j), {32'd0, obs[j].addr, obs[j].data}, {32'd0, exp2[j]});
      chk("rr_done", {62'd0, done}, 64'd3);
    end

    // Asynchronous reset while the engine waits on the ROM.
    rom_lat = 6;
    wr(0, 2'd0, 16'h0500); wr(0, 2'd2, 16'h6000);
    clear_mon();
    start(0, 1'b0, 2);
    for (int n = 0; n < 20 && load_cnt == 0; n++) tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_proc_en",   {63'd0, proc_en},   64'd1);
    chk("arst_load_rom",  {63'd0, load_rom},  64'd0);
    chk("arst_dst_write", {63'd0, dst_write}, 64'd0);
    chk("arst_src_addr",  {41'd0, src_addr},  64'd0);
    chk("arst_busy",      {62'd0, busy},      64'd0);
    chk("arst_done",      {62'd0, done},      64'd0);
    tick();
    rst = 1'b0;
    obs.delete();
    for (int n = 0; n < 12; n++) tick();
    chk("arst_no_write", 64'(obs.size()), 64'd0);
    chk("arst_busy_after", {62'd0, busy}, 64'd0);
    chk("arst_done_after", {62'd0, done}, 64'd0);

    // Random rounds against a round-robin word-order model.
    rom_rand = 1'b1;
    mptr = 1;
    for (int r = 0; r < 30; r++) begin
      logic [22:0] rs [2];
      logic [15:0] rd [2];
      int          rl [2];
      bit          rf [2];
      int          k  [2];
      int          first, copies;
      for (int c = 0; c < 2; c++) begin
        rf[c] = 1'($urandom);
        rl[c] = int'($urandom_range(0, 5));
        rs[c] = ($urandom_range(0, 3) == 0) ? 23'h7FFFFD : 23'($urandom);
        rd[c] = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
        wr(c, 2'd0, rs[c][15:0]);
        wr(c, 2'd1, {9'd0, rs[c][22:16]});
        wr(c, 2'd2, rd[c]);
      end
      clear_mon();
      first = int'($urandom_range(0, 1));
      start(first, rf[first], rl[first]);
      start(1 - first, rf[1-first], rl[1-first]);
      wait_idle(1'b1);

      expq.delete();
      k[0] = 0; k[1] = 0;
      copies = (rf[0] ? 0 : rl[0]) + (rf[1] ? 0 : rl[1]);
      while (k[0] < rl[0] || k[1] < rl[1]) begin
        for (int s = 1; s <= 2; s++) begin
          int c;
          c = (mptr + s) % 2;
          if (k[c] < rl[c]) begin
            expq.push_back('{16'(rd[c] + 16'(k[c])),
                             rf[c] ? rs[c][15:0] : rom(23'(rs[c] + 23'(k[c]))), 0});
            k[c]++;
            mptr = c;
            break;
          end
        end
      end
      chk($sformatf("rnd%0d_count", r), 64'(obs.size()), 64'(expq.size()));
      for (int j = 0; j < obs.size() && j < expq.size(); j++)
        chk($sformatf("rnd%0d_word%0d", r, j), {32'd0, obs[j].addr, obs[j].data},
            {32'd0, expq[j].addr, expq[j].data});
      chk($sformatf("rnd%0d_loads", r), 64'(load_cnt), 64'(copies));
      chk($sformatf("rnd%0d_done", r), {62'd0, done}, 64'd3);
      chk($sformatf("rnd%0d_busy", r), {62'd0, busy}, 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
